// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared widths, reset default, branch opcodes and fetch helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int ADDR_W     = 8;
  localparam int INSN_W     = 16;
  localparam int INSN_BYTES = 2;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 8'h00;

  // Major opcodes of the control-transfer instructions (insn[15:12]).
  localparam logic [3:0] OP_BR     = 4'hC;
  localparam logic [3:0] OP_BR_SUB = 4'hD;
  localparam logic [3:0] OP_RET    = 4'hE;

  typedef enum logic [2:0] {
    SEL_SEQ   = 3'd0,
    SEL_STALL = 3'd1,
    SEL_BR    = 3'd2,
    SEL_CALL  = 3'd3,
    SEL_RET   = 3'd4
  } pc_sel_e;

  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:1], 1'b0};
  endfunction

endpackage

`default_nettype wire

// File: rtl/return_addr_stack.sv
// ============================================================================
// Module   : return_addr_stack
// Purpose  : Circular LIFO of return addresses; full push overwrites oldest.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module return_addr_stack
  import cpu_pkg::*;
#(
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  output logic [ADDR_W-1:0] top,
  output logic              full,
  output logic              empty
);

  localparam int c_ptr_w = $clog2(RAS_DEPTH);
  localparam int c_cnt_w = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0]  r_mem [RAS_DEPTH];
  logic [c_ptr_w-1:0] r_ptr;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_ptr_w-1:0] w_top_idx;

  assign w_top_idx = r_ptr - c_ptr_w'(1);
  assign top       = r_mem[w_top_idx];
  assign full      = (r_cnt == c_cnt_w'(RAS_DEPTH));
  assign empty     = (r_cnt == '0);

  // The pointer wraps freely; the count saturates so an overflowed stack
  // still unwinds exactly RAS_DEPTH entries before reporting empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr <= '0;
      r_cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (pop) begin
      if (!empty) begin
        r_ptr <= w_top_idx;
        r_cnt <= r_cnt - c_cnt_w'(1);
      end
    end else if (push) begin
      r_mem[r_ptr] <= push_addr;
      r_ptr        <= r_ptr + c_ptr_w'(1);
      if (!full) begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Purpose  : PC / instruction-register fetch stage with branch, call, return.
//            RAS_ERR_FLAG_EN adds the sticky ras_err overflow/underflow port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              br_taken,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [INSN_W-1:0] ins_in,
  output logic [ADDR_W-1:0] pc,
  output logic [INSN_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
`ifdef RAS_ERR_FLAG_EN
  output logic              ras_err,
`endif
  output logic              ir_valid
);

  localparam logic [ADDR_W-1:0] c_step = ADDR_W'(INSN_BYTES);

  logic [ADDR_W-1:0] r_pc;
  logic [INSN_W-1:0] r_ir;
  logic [ADDR_W-1:0] r_ir_pc;
  logic              r_ir_valid;

  pc_sel_e           w_sel;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_top;
  logic              w_full;
  logic              w_empty;
  logic [ADDR_W-1:0] w_ret_pc;

  // Controls describe the instruction in ir, so a bubble ignores them all.
  always_comb begin
    w_sel = SEL_SEQ;
    if (r_ir_valid) begin
      if (ret)           w_sel = SEL_RET;
      else if (call)     w_sel = SEL_CALL;
      else if (br_taken) w_sel = SEL_BR;
      else if (stall)    w_sel = SEL_STALL;
    end
  end

  assign w_push   = (w_sel == SEL_CALL);
  assign w_pop    = (w_sel == SEL_RET);
  assign w_ret_pc = w_empty ? RESET_PC : w_top;

  return_addr_stack #(
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pop       (w_pop),
    .push_addr (r_ir_pc + c_step),
    .top       (w_top),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_ir_pc    <= '0;
      r_ir_valid <= 1'b0;
    end else begin
      case (w_sel)
        SEL_RET: begin
          r_pc       <= align_addr(w_ret_pc);
          r_ir_valid <= 1'b0;
        end
        SEL_CALL, SEL_BR: begin
          r_pc       <= align_addr(br_target);
          r_ir_valid <= 1'b0;
        end
        SEL_STALL: ;
        default: begin
          r_ir       <= ins_in;
          r_ir_pc    <= r_pc;
          r_ir_valid <= 1'b1;
          r_pc       <= r_pc + c_step;
        end
      endcase
    end
  end

`ifdef RAS_ERR_FLAG_EN
  logic r_ras_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ras_err <= 1'b0;
    end else if ((w_push && w_full) || (w_pop && w_empty)) begin
      r_ras_err <= 1'b1;
    end
  end

  assign ras_err = r_ras_err;
`else
  logic w_unused_full;
  assign w_unused_full = w_full;
`endif

  assign pc       = r_pc;
  assign ir       = r_ir;
  assign ir_pc    = r_ir_pc;
  assign ir_valid = r_ir_valid;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed table-driven bench for fetch_unit (RAS_DEPTH = 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, br_taken, call, ret;
  logic [7:0]  br_target;
  logic [15:0] ins_in;
  logic [7:0]  pc, ir_pc;
  logic [15:0] ir;
  logic        ir_valid;
`ifdef RAS_ERR_FLAG_EN
  logic        ras_err;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  // Instruction memory model: the word fetched at address a is 16'hC000 | a.
  assign ins_in = 16'hC000 | {8'h00, pc};

  fetch_unit #(
    .RAS_DEPTH (4),
    .RESET_PC  (8'h00)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .br_taken  (br_taken),
    .call      (call),
    .ret       (ret),
    .br_target (br_target),
    .ins_in    (ins_in),
    .pc        (pc),
    .ir        (ir),
    .ir_pc     (ir_pc),
`ifdef RAS_ERR_FLAG_EN
    .ras_err   (ras_err),
`endif
    .ir_valid  (ir_valid)
  );

  typedef struct {
    logic       stall;
    logic       br;
    logic       call;
    logic       ret;
    logic [7:0] tgt;
    logic [7:0] pc;
    logic [7:0] ir_pc;
    logic       v;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic b, input logic c, input logic r,
                      input logic [7:0] t);
    stall = s; br_taken = b; call = c; ret = r; br_target = t;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string tag, input logic [7:0] epc,
                           input logic [7:0] eirpc, input logic ev);
    chk({tag, " pc"}, {8'h00, pc}, {8'h00, epc});
    chk({tag, " ir_pc"}, {8'h00, ir_pc}, {8'h00, eirpc});
    chk({tag, " ir_valid"}, {15'h0, ir_valid}, {15'h0, ev});
    chk({tag, " ir"}, ir, 16'hC000 | {8'h00, eirpc});
  endtask

  task automatic expect_reset(input string tag);
    chk({tag, " pc"}, {8'h00, pc}, 16'h0000);
    chk({tag, " ir"}, ir, 16'h0000);
    chk({tag, " ir_pc"}, {8'h00, ir_pc}, 16'h0000);
    chk({tag, " ir_valid"}, {15'h0, ir_valid}, 16'h0000);
`ifdef RAS_ERR_FLAG_EN
    chk({tag, " ras_err"}, {15'h0, ras_err}, 16'h0000);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] call_tgt [5];
    logic [7:0] ret_exp  [5];

    //            stall br  call ret  tgt    pc     ir_pc  v
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 8'h00, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h04, 8'h02, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h06, 8'h04, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h08, 8'h06, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h21, 8'h20, 8'h06, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h80, 8'h22, 8'h20, 1'b1}; // br in bubble ignored
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h24, 8'h22, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h25, 8'h24, 8'h22, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h26, 8'h24, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h28, 8'h26, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h2A, 8'h28, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h34, 8'h34, 8'h28, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h36, 8'h34, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h36, 8'h34, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h2A, 8'h34, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h2C, 8'h2A, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h2A, 1'b0}; // empty RAS
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 8'h00, 1'b1};

    call_tgt = '{8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    ret_exp  = '{8'h72, 8'h62, 8'h52, 8'h42, 8'h00};

    rst = 1'b0;
    stall = 1'b0; br_taken = 1'b0; call = 1'b0; ret = 1'b0; br_target = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    expect_reset("reset");
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].stall, tbl[i].br, tbl[i].call, tbl[i].ret, tbl[i].tgt);
      expect_st($sformatf("row%0d", i), tbl[i].pc, tbl[i].ir_pc, tbl[i].v);
    end

    // pc wrap at the top of memory, then a three-cycle stall.
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
    expect_st("wrap br", 8'hFE, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    expect_st("wrap fe", 8'h00, 8'hFE, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    expect_st("wrap 00", 8'h02, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      expect_st($sformatf("stall%0d", i), 8'h02, 8'h00, 1'b1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    expect_st("resume0", 8'h04, 8'h02, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    expect_st("resume1", 8'h06, 8'h04, 1'b1);

    // Five nested calls overflow the four-entry RAS, then unwind.
`ifdef RAS_ERR_FLAG_EN
    chk("ras_err pre", {15'h0, ras_err}, 16'h0000);
`endif
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, call_tgt[i]);
      chk($sformatf("call%0d pc", i), {8'h00, pc}, {8'h00, call_tgt[i]});
`ifdef RAS_ERR_FLAG_EN
      if (i == 3) chk("ras_err at full", {15'h0, ras_err}, 16'h0000);
`endif
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      expect_st($sformatf("call%0d fill", i), call_tgt[i] + 8'h02, call_tgt[i], 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      chk($sformatf("ret%0d pc", i), {8'h00, pc}, {8'h00, ret_exp[i]});
      chk($sformatf("ret%0d ir_valid", i), {15'h0, ir_valid}, 16'h0000);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      chk($sformatf("ret%0d ir_pc", i), {8'h00, ir_pc}, {8'h00, ret_exp[i]});
    end
`ifdef RAS_ERR_FLAG_EN
    chk("ras_err post", {15'h0, ras_err}, 16'h0001);
`endif

    // call and ret together: ret wins and nothing is pushed.
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h90);
    expect_st("call90", 8'h90, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    expect_st("call90 fill", 8'h92, 8'h90, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'hC0);
    expect_st("call+ret", 8'h02, 8'h90, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    expect_st("call+ret fill", 8'h04, 8'h02, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    expect_st("no push", 8'h00, 8'h02, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    expect_st("no push fill", 8'h02, 8'h00, 1'b1);

    // Reset asserted while stalled and with a branch pending.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    expect_st("pre-rst stall", 8'h02, 8'h00, 1'b1);
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h50);
    expect_reset("mid rst");
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    expect_st("post rst", 8'h02, 8'h00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
